row_mem_responder: RTL

Synthesizable memory-side responder for the row-streaming request/response interface used by the hash-join engines. Accepts 8-byte row-word read requests (`row_rq_*`), reads a local 64-bit-wide row memory, and returns data in request order on `row_rs_*`, honouring both stall directions. It stands in for the coprocessor memory port in standalone build/probe bring-up and regression.

---
 rtl/row_mem_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/row_mem_responder.sv
// row_mem_responder: in-order 64-bit row-word read responder on a local memory; `ROW_RSP_ERR_CHECK_EN enables address checks.
// Latency: a request accepted at one edge is registered on row_rs_* LATENCY+1 edges later; one request per cycle sustained.
// Backpressure: row_rq_stall_out rises once in-flight plus queued reaches FIFO_DEPTH; row_rs_stall_in holds the FIFO.

module row_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   input  logic         out_rdy,
   output logic         out_vld,
   output logic [W-1:0] out_dat
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          pop;

   // No full check: the owner bounds pushes with credits.
   assign out_vld = (count != '0);
   assign out_dat = store[rd_ptr];
   assign pop     = out_vld && out_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (in_vld) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, in_vld} - {{PW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (in_vld) store[wr_ptr] <= in_dat;
   end
endmodule

module row_mem_responder #(
   parameter int ADDR_W     = 10,
   parameter int LATENCY    = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [47:0]       base_adr_in,
   input  logic              row_rq_vld_in,
   input  logic [47:0]       row_rq_vadr_in,
   output logic              row_rq_stall_out,
   input  logic              row_rs_stall_in,
   output logic              row_rs_vld_out,
   output logic [63:0]       row_rs_data_out,
   input  logic              load_we_in,
   input  logic [ADDR_W-1:0] load_idx_in,
   input  logic [63:0]       load_data_in,
   output logic [63:0]       rq_count_out,
   output logic [63:0]       rs_count_out,
   output logic              idle_out,
   output logic              err_out
);
   localparam int UW = $clog2(FIFO_DEPTH) + 1;

   logic [63:0]        mem [1 << ADDR_W];
   logic               accept;
   logic               pop;
   logic               bad;
   logic [47:0]        diff;
   logic [ADDR_W-1:0]  idx;
   logic [LATENCY-1:0] pipe_vld;
   logic [63:0]        pipe_dat [LATENCY];
   logic [UW-1:0]      used;
   logic [UW-1:0]      used_next;
   logic               fifo_vld;
   logic [63:0]        fifo_dat;

   assign accept = row_rq_vld_in && !row_rq_stall_out;
   assign pop    = fifo_vld && !row_rs_stall_in;
   assign diff   = row_rq_vadr_in - base_adr_in;
   assign idx    = diff[ADDR_W+2:3];

`ifdef ROW_RSP_ERR_CHECK_EN
   logic unused_diff;
   assign unused_diff = ^diff[2:0];
   assign bad = (row_rq_vadr_in < base_adr_in) || (row_rq_vadr_in[2:0] != 3'd0) ||
                (|diff[47:ADDR_W+3]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               err_out <= 1'b0;
      else if (accept && bad) err_out <= 1'b1;
   end
`else
   logic unused_diff;
   assign unused_diff = ^{diff[2:0], diff[47:ADDR_W+3]};
   assign bad     = 1'b0;
   assign err_out = 1'b0;
`endif

   // Nonblocking write against a same-edge read gives read-first behaviour.
   always_ff @(posedge clk) begin
      if (load_we_in) mem[load_idx_in] <= load_data_in;
   end

   always_ff @(posedge clk) begin
      pipe_dat[0] <= bad ? 64'hDEAD_BEEF_DEAD_BEEF : mem[idx];
      for (int i = 1; i < LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= accept;
         for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   row_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (pipe_vld[LATENCY-1]),
      .in_dat  (pipe_dat[LATENCY-1]),
      .out_rdy (!row_rs_stall_in),
      .out_vld (fifo_vld),
      .out_dat (fifo_dat)
   );

   always_comb begin
      used_next = used;
      if (accept && !pop)      used_next = used + 1'b1;
      else if (!accept && pop) used_next = used - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         used             <= '0;
         row_rq_stall_out <= 1'b0;
         row_rs_vld_out   <= 1'b0;
         row_rs_data_out  <= '0;
         rq_count_out     <= '0;
         rs_count_out     <= '0;
      end else begin
         used             <= used_next;
         row_rq_stall_out <= (used_next >= UW'(FIFO_DEPTH));
         row_rs_vld_out   <= pop;
         if (pop) row_rs_data_out <= fifo_dat;
         rq_count_out <= rq_count_out + {63'd0, accept};
         rs_count_out <= rs_count_out + {63'd0, pop};
      end
   end

   assign idle_out = (used == '0) && !row_rs_vld_out;
endmodule
